// File: rtl/dm_pkg.sv
// Shared types and access checks for the data-memory arbiter.
// Encodings match the dm access-type field.
package dm_pkg;

  typedef enum logic [2:0] {
    DM_W  = 3'b000,
    DM_H  = 3'b100,
    DM_HU = 3'b101,
    DM_B  = 3'b110,
    DM_BU = 3'b111
  } dm_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic type_legal(
    input logic [2:0] t
  );
    logic ok;
    unique case (t)
      DM_W, DM_H, DM_HU,
      DM_B, DM_BU: ok = 1'b1;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic aligned(
    input logic [2:0] t,
    input logic [1:0] a
  );
    logic ok;
    unique case (t)
      DM_W:        ok = (a == 2'b00);
      DM_H, DM_HU: ok = ~a[0];
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_arb_rr_arb2.sv
// Two-requester round-robin picker.
// On a tie the port not served last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       upd_idx_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = 1'b0;
    unique case (1'b1)
      (req_i == 2'b11): gnt_idx_o = ~last_q;
      (req_i == 2'b10): gnt_idx_o = 1'b1;
      default:          gnt_idx_o = 1'b0;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (update_i) last_d = upd_idx_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/dm_arb.sv
// Two-port arbiter/sequencer in front of the single-port dm.
// Holds dm inputs stable for LAT cycles, then acks for one cycle.
module dm_arb
  import dm_pkg::*;
#(
  parameter int unsigned LAT = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [2:0]  type0,
  input  logic [2:0]  type1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        dm_w,
  output logic [2:0]  dm_type,
  output logic [31:0] dm_a,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dm_w_q, dm_w_d;
  logic [2:0]  dm_type_q, dm_type_d;
  logic [31:0] dm_a_q, dm_a_d;
  logic [31:0] dm_wd_q, dm_wd_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        gnt_vld, gnt_idx, upd;
  logic        s_we, s_ok;
  logic [2:0]  s_type;
  logic [31:0] s_addr, s_wdata;

  rr_arb2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_i     ({req1, req0}),
    .update_i  (upd),
    .upd_idx_i (gnt_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  assign s_we    = gnt_idx ? we1    : we0;
  assign s_type  = gnt_idx ? type1  : type0;
  assign s_addr  = gnt_idx ? addr1  : addr0;
  assign s_wdata = gnt_idx ? wdata1 : wdata0;
  assign s_ok    = type_legal(s_type)
                && aligned(s_type, s_addr[1:0]);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    dm_w_d    = dm_w_q;
    dm_type_d = dm_type_q;
    dm_a_d    = dm_a_q;
    dm_wd_d   = dm_wd_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    upd       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          gnt_d = gnt_idx;
          if (s_ok) begin
            err_d     = 1'b0;
            dm_w_d    = s_we;
            dm_type_d = s_type;
            dm_a_d    = s_addr;
            dm_wd_d   = s_wdata;
            cnt_d     = CNT_INIT;
            state_d   = S_BUSY;
          end else begin
            // rejected: never reaches dm
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          dm_w_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        dm_w_d = 1'b0;
        upd    = 1'b1;
        if (!err_q) begin
          if (gnt_q) rdata1_d = dm_rd;
          else       rdata0_d = dm_rd;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 4'd0;
      dm_w_q    <= 1'b0;
      dm_type_q <= 3'b000;
      dm_a_q    <= 32'd0;
      dm_wd_q   <= 32'd0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      dm_w_q    <= dm_w_d;
      dm_type_q <= dm_type_d;
      dm_a_q    <= dm_a_d;
      dm_wd_q   <= dm_wd_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign ack0 = (state_q == S_DONE) && !gnt_q;
  assign ack1 = (state_q == S_DONE) &&  gnt_q;
  assign err0 = ack0 && err_q;
  assign err1 = ack1 && err_q;

  // read data is visible in the ack cycle itself
  assign rdata0 = (ack0 && !err_q) ? dm_rd : rdata0_q;
  assign rdata1 = (ack1 && !err_q) ? dm_rd : rdata1_q;

  assign dm_w    = dm_w_q;
  assign dm_type = dm_type_q;
  assign dm_a    = dm_a_q;
  assign dm_wd   = dm_wd_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_dm_arb.sv
// Scoreboard bench for dm_arb with a behavioural byte-addressed dm.
// Drivers push expected acks per port; a negedge monitor checks them.
module tb_dm_arb;

  localparam int LAT = 6;
  localparam int BND = 2 * (LAT + 2);

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [2:0]  type0, type1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        dm_w;
  logic [2:0]  dm_type;
  logic [31:0] dm_a, dm_wd, dm_rd;
  logic        busy;

  always #5 clk = ~clk;

  dm_arb #(.LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .type0(type0), .type1(type1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .dm_w(dm_w), .dm_type(dm_type),
    .dm_a(dm_a), .dm_wd(dm_wd),
    .dm_rd(dm_rd), .busy(busy)
  );

  // behavioural dm, little-endian bytes
  logic [7:0] mem [0:255];
  logic       mem_clr;
  logic [7:0] a0, a1, a2, a3;
  assign a0 = dm_a[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (dm_w) begin
      mem[a0] <= dm_wd[7:0];
      if (dm_type[2] == 1'b0 || dm_type[1] == 1'b0)
        mem[a1] <= dm_wd[15:8];
      if (dm_type == 3'b000) begin
        mem[a2] <= dm_wd[23:16];
        mem[a3] <= dm_wd[31:24];
      end
    end
  end

  always_comb begin
    dm_rd = 32'h0;
    case (dm_type)
      3'b000: dm_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
      3'b100: dm_rd = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b101: dm_rd = {16'h0, mem[a1], mem[a0]};
      3'b110: dm_rd = {{24{mem[a0][7]}}, mem[a0]};
      3'b111: dm_rd = {24'h0, mem[a0]};
      default: dm_rd = 32'h0;
    endcase
  end

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] rd;
    int          start;
    int          lat;
    logic        exact;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   order[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   dmw_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dm_w) dmw_cnt++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic check_port(input int p);
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat;
    rd = (p == 0) ? rdata0 : rdata1;
    er = (p == 0) ? err0 : err1;
    total++;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      bad++;
      $display("FAIL unexpected_ack port%0d got=ack want=none", p);
      return;
    end
    e = (p == 0) ? q0.pop_front() : q1.pop_front();
    lat = cyc - e.start;
    if (er !== e.err) begin
      bad++;
      $display("FAIL err_port%0d got=%b want=%b", p, er, e.err);
    end
    total++;
    if (e.chk && rd !== e.rd) begin
      bad++;
      $display("FAIL rdata_port%0d got=%h want=%h", p, rd, e.rd);
    end
    total++;
    if ((e.exact && lat != e.lat) || (!e.exact && lat > e.lat)) begin
      bad++;
      $display("FAIL latency_port%0d got=%0d want=%s%0d",
               p, lat, e.exact ? "" : "<=", e.lat);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (ack0 || ack1)) begin
      total++;
      if (ack0 && ack1) begin
        bad++;
        $display("FAIL coincident_ack got=11 want=one-hot");
      end
      if (ack0) begin order.push_back(0); check_port(0); end
      if (ack1) begin order.push_back(1); check_port(1); end
    end
  end

  task automatic issue(input int p, input logic we,
                       input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] wd, input logic er,
                       input logic ck, input logic [31:0] rd,
                       input int lat, input logic exact);
    exp_t e;
    int n;
    e.err = er; e.chk = ck; e.rd = rd;
    e.start = cyc; e.lat = lat; e.exact = exact;
    if (p == 0) begin
      q0.push_back(e);
      we0 = we; type0 = t; addr0 = a; wdata0 = wd; req0 = 1'b1;
    end else begin
      q1.push_back(e);
      we1 = we; type1 = t; addr1 = a; wdata1 = wd; req1 = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((p == 0) ? ack0 : ack1) && n < 200);
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL timeout_port%0d got=no_ack want=ack", p);
    end
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    int snap;
    reset = 1'b1; mem_clr = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    type0 = 0; type1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_dm_w", {31'b0, dm_w}, 0);
    chk("rst_dm_a", dm_a, 0);
    chk("rst_acks", {30'b0, ack0, ack1}, 0);
    chk("rst_rdata0", rdata0, 0);
    @(posedge clk); #1;

    // store then load, port 0
    issue(0, 1, 3'b000, 32'h8, 32'hDEADBEEF, 0, 0, 0, LAT+1, 1);
    issue(0, 0, 3'b000, 32'h8, 32'h0, 0, 1, 32'hDEADBEEF, LAT+1, 1);
    @(negedge clk);
    chk("rdata0_hold", rdata0, 32'hDEADBEEF);
    @(posedge clk); #1;

    // byte/half sign handling
    issue(0, 1, 3'b000, 32'h4, 32'h0000F08A, 0, 0, 0, LAT+1, 1);
    issue(0, 0, 3'b111, 32'h4, 0, 0, 1, 32'h0000008A, LAT+1, 1);
    issue(0, 0, 3'b110, 32'h4, 0, 0, 1, 32'hFFFFFF8A, LAT+1, 1);
    issue(0, 0, 3'b100, 32'h4, 0, 0, 1, 32'hFFFFF08A, LAT+1, 1);
    issue(0, 0, 3'b101, 32'h4, 0, 0, 1, 32'h0000F08A, LAT+1, 1);

    // simultaneous requests after a fresh reset
    do_reset();
    order.delete();
    fork
      begin
        issue(0, 1, 3'b000, 32'h10, 32'h11112222, 0, 0, 0, BND, 0);
        issue(0, 0, 3'b000, 32'h10, 0, 0, 1, 32'h11112222, BND, 0);
      end
      begin
        issue(1, 1, 3'b000, 32'h20, 32'h33334444, 0, 0, 0, BND, 0);
        issue(1, 0, 3'b000, 32'h20, 0, 0, 1, 32'h33334444, BND, 0);
      end
    join
    chk("rr_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk($sformatf("rr_order%0d", i), order[i], i % 2);

    // rejects on port 1, memory must be untouched
    issue(1, 1, 3'b000, 32'h0, 32'hCAFEF00D, 0, 0, 0, LAT+1, 1);
    snap = dmw_cnt;
    issue(1, 1, 3'b010, 32'h0, 32'hFFFFFFFF, 1, 0, 0, 1, 1);
    issue(1, 1, 3'b100, 32'h3, 32'h12345678, 1, 0, 0, 1, 1);
    chk("rej_no_dm_w", dmw_cnt - snap, 0);
    issue(1, 0, 3'b000, 32'h0, 0, 0, 1, 32'hCAFEF00D, LAT+1, 1);

    // reset in the middle of a port-0 store
    we0 = 1; type0 = 3'b000; addr0 = 32'h30;
    wdata0 = 32'h55; req0 = 1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_busy", {31'b0, busy}, 0);
    chk("mid_dm_w", {31'b0, dm_w}, 0);
    chk("mid_dm_a", dm_a, 0);
    chk("mid_dm_wd", dm_wd, 0);
    chk("mid_dm_type", {29'b0, dm_type}, 0);
    chk("mid_ack0", {31'b0, ack0}, 0);
    chk("mid_rdata0", rdata0, 0);
    chk("mid_rdata1", rdata1, 0);
    @(posedge clk);
    #1 reset = 1'b0; req0 = 0;
    issue(1, 0, 3'b000, 32'h40, 0, 0, 1, 32'h0, LAT+1, 1);

    // starvation: port 0 re-requests continuously
    fork
      begin
        repeat (3)
          issue(0, 0, 3'b000, 32'h8, 0, 0, 1, 32'hDEADBEEF, BND, 0);
      end
      begin
        @(posedge clk);
        #1;
        issue(1, 0, 3'b000, 32'h4, 0, 0, 1, 32'h0000F08A, BND, 0);
      end
    join

    repeat (3) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
